// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column/row, active-video and frame-start from a
// VGA hsync/vsync pair, locks after consecutive clean frames and pulses err
// on any sync edge that departs from the nominal timing once locked.
module vga_sync_decoder #(
  parameter  int TOTAL_COLS  = 800,
  parameter  int ACTIVE_COLS = 640,
  parameter  int H_FRONT     = 16,
  parameter  int TOTAL_ROWS  = 525,
  parameter  int ACTIVE_ROWS = 480,
  parameter  int V_FRONT     = 10,
  parameter  int LOCK_FRAMES = 2,
  localparam int CW          = $clog2(TOTAL_COLS),
  localparam int RW          = $clog2(TOTAL_ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          active,
  output logic          frame_start,
  output logic          locked,
  output logic          err
);

  localparam logic [CW-1:0] COL_LAST   = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] H_EDGE_COL = CW'(ACTIVE_COLS + H_FRONT);
  localparam logic [RW-1:0] V_EDGE_ROW = RW'(ACTIVE_ROWS + V_FRONT);
  localparam logic [CW-1:0] COL_ACT    = CW'(ACTIVE_COLS);
  localparam logic [RW-1:0] ROW_ACT    = RW'(ACTIVE_ROWS);
  localparam logic [2:0]    LOCK_CNT   = 3'(LOCK_FRAMES);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  // Two-stage sync sampling; edge detection looks at the s1/s2 pair.
  logic hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;

  // Position counters; they always describe the sample that was in s1 one
  // cycle earlier, so they double as the col/row outputs.
  logic [CW-1:0] col_q, col_d, col_inc;
  logic [RW-1:0] row_q, row_d, row_inc;

  // Lock tracking: armed marks that a vsync edge has opened a frame window,
  // clean marks that no mismatch has been seen inside the current window.
  logic [0:0] state_q, state_d;
  logic [2:0] good_cnt_q, good_cnt_d, good_inc;
  logic       armed_q, armed_d;
  logic       clean_q, clean_d;

  logic active_q, active_d;
  logic frame_start_q, frame_start_d;
  logic err_q, err_d;

  logic h_edge, v_edge, h_pred, v_pred, mismatch, locked_next;

  // Next-state logic: counter advance, edge prediction, resync and lock FSM.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it unassigned, which would infer a latch.
    hs_s1_d    = hsync;
    hs_s2_d    = hs_s1_q;
    vs_s1_d    = vsync;
    vs_s2_d    = vs_s1_q;

    col_inc    = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    row_inc    = row_q;
    if (col_q == COL_LAST) begin
      row_inc = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end

    h_edge     = ~hs_s1_q & hs_s2_q;
    v_edge     = ~vs_s1_q & vs_s2_q;
    h_pred     = (col_inc == H_EDGE_COL);
    v_pred     = (row_inc == V_EDGE_ROW) && (col_inc == '0);
    mismatch   = (h_edge ^ h_pred) | (v_edge ^ v_pred);

    // A vsync edge pins both counters and wins over a coincident hsync edge;
    // a predicted edge that never arrives leaves the counters free-running.
    col_d      = col_inc;
    row_d      = row_inc;
    if (v_edge) begin
      col_d = '0;
      row_d = V_EDGE_ROW;
    end else if (h_edge) begin
      col_d = H_EDGE_COL;
    end

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    armed_d    = armed_q;
    clean_d    = clean_q;
    err_d      = 1'b0;
    good_inc   = good_cnt_q + 3'd1;

    case (state_q)
      ST_UNLOCKED: begin
        if (v_edge) begin
          clean_d = 1'b1;
          armed_d = 1'b1;
          if (!armed_q) begin
            good_cnt_d = '0;
          end else if (clean_q && !mismatch) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_CNT) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (mismatch) begin
          good_cnt_d = '0;
          clean_d    = 1'b0;
        end
      end
      default: begin
        if (mismatch) begin
          err_d      = 1'b1;
          state_d    = ST_UNLOCKED;
          good_cnt_d = '0;
          armed_d    = 1'b0;
          clean_d    = 1'b0;
        end
      end
    endcase

    locked_next   = (state_d == ST_LOCKED);
    active_d      = locked_next && (col_d < COL_ACT) && (row_d < ROW_ACT);
    frame_start_d = locked_next && (col_d == '0) && (row_d == '0);
  end

  // State registers; sync stages reset high so release creates no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is plain flops, so every one takes a reset value; non-blocking updates keep flops order-independent.
    if (!rst_n) begin
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      col_q         <= '0;
      row_q         <= '0;
      state_q       <= ST_UNLOCKED;
      good_cnt_q    <= '0;
      armed_q       <= 1'b0;
      clean_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hs_s1_q       <= hs_s1_d;
      hs_s2_q       <= hs_s2_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      col_q         <= col_d;
      row_q         <= row_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      armed_q       <= armed_d;
      clean_q       <= clean_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder on a reduced 40x30 raster: an ideal sync
// generator with optional dropped hsync, phase shift and mid-frame reset,
// checked every cycle against a position/lock reference model.
module tb_vga_sync_decoder;

  localparam int TC = 40;
  localparam int AC = 32;
  localparam int HF = 2;
  localparam int TR = 30;
  localparam int AR = 24;
  localparam int VF = 2;
  localparam int LF = 2;
  localparam int HW = 3;
  localparam int VW = 2;
  localparam int HE = AC + HF;
  localparam int VE = AR + VF;
  localparam int F  = TC * TR;
  localparam int CW = $clog2(TC);
  localparam int RW = $clog2(TR);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsync, vsync;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          active, frame_start, locked, err;

  vga_sync_decoder #(
    .TOTAL_COLS(TC), .ACTIVE_COLS(AC), .H_FRONT(HF),
    .TOTAL_ROWS(TR), .ACTIVE_ROWS(AR), .V_FRONT(VF), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .col(col), .row(row), .active(active), .frame_start(frame_start),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   col;
    int   row;
    logic active;
    logic fs;
    logic locked;
    logic err;
  } out_t;

  typedef struct {
    int   col;
    int   row;
    logic active;
  } act_vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // generator state
  int   gen_pos, shift, drop_row, vfall_cnt, v_lock_cyc;
  logic drop_pending;

  // reference model state: linear position of the last sample, lock bookkeeping
  int   m_pos, m_vcnt;
  logic m_prev_h, m_prev_v, m_locked;
  out_t exp_o, pend_o;

  act_vec_t act_tbl[7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Position is a linear index into the frame; an hsync edge snaps the
  // column within the current line, a vsync edge snaps to (VE, 0).
  // Lock: count vsync edges since the last mismatch/unlock; L+1 clean ones lock.
  task automatic model_step(input logic h, input logic v);
    logic he, ve, mis;
    int   np, newp;
    he = !h && m_prev_h;
    ve = !v && m_prev_v;
    m_prev_h = h;
    m_prev_v = v;
    np   = (m_pos + 1) % F;
    mis  = (he != (np % TC == HE)) || (ve != (np == VE * TC));
    newp = ve ? VE * TC : (he ? (np / TC) * TC + HE : np);
    pend_o.err = 1'b0;
    if (m_locked) begin
      if (mis) begin
        pend_o.err = 1'b1;
        m_locked   = 1'b0;
        m_vcnt     = 0;
      end
    end else begin
      if (mis) m_vcnt = ve ? 1 : 0;
      else if (ve) m_vcnt++;
      if (ve && !mis && m_vcnt >= LF + 1) m_locked = 1'b1;
    end
    m_pos         = newp;
    pend_o.col    = newp % TC;
    pend_o.row    = newp / TC;
    pend_o.locked = m_locked;
    pend_o.active = m_locked && (pend_o.col < AC) && (pend_o.row < AR);
    pend_o.fs     = m_locked && (newp == 0);
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_prev_h = 1'b1;
    m_prev_v = 1'b1;
    m_locked = 1'b0;
    m_vcnt   = 0;
    exp_o    = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    model_step(1'b1, 1'b1);
  endtask

  task automatic drive();
    int   sp, c, r;
    logic nh, nv;
    sp = (gen_pos - shift + F) % F;
    c  = sp % TC;
    r  = sp / TC;
    nh = !(c >= HE && c < HE + HW);
    nv = !(r >= VE && r < VE + VW);
    if (drop_pending && r == drop_row) nh = 1'b1;
    if (drop_pending && sp == drop_row * TC + TC - 1) drop_pending = 1'b0;
    if (!nv && vsync && rst_n) begin
      vfall_cnt++;
      if (vfall_cnt == LF + 1) v_lock_cyc = cyc;
    end
    hsync = nh;
    vsync = nv;
  endtask

  task automatic compare_outputs();
    checks++;
    if (int'(col) != exp_o.col || int'(row) != exp_o.row || active !== exp_o.active ||
        frame_start !== exp_o.fs || locked !== exp_o.locked || err !== exp_o.err) begin
      errors++;
      $display("FAIL model cyc=%0d got col=%0d row=%0d act=%0b fs=%0b lk=%0b err=%0b expected col=%0d row=%0d act=%0b fs=%0b lk=%0b err=%0b",
               cyc, col, row, active, frame_start, locked, err,
               exp_o.col, exp_o.row, exp_o.active, exp_o.fs, exp_o.locked, exp_o.err);
    end
  endtask

  // One pixel clock: update model with the sample captured at this edge,
  // drive the next generator sample, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      exp_o = pend_o;
      model_step(hsync, vsync);
    end
    cyc++;
    #1;
    gen_pos = (gen_pos + 1) % F;
    drive();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic wait_lock(input int budget, input bit chk_latency, input string name);
    int n = 0;
    int n_err = 0;
    while (locked !== 1'b1 && n < budget) begin
      tick();
      if (err === 1'b1) n_err++;
      n++;
    end
    check({name, "_locked"}, int'(locked), 1);
    if (chk_latency) begin
      check({name, "_lock_latency"}, cyc - v_lock_cyc, 2);
      check({name, "_err_before_lock"}, n_err, 0);
    end
  endtask

  task automatic wait_pos(input int c, input int r);
    int n = 0;
    tick();
    while (!(exp_o.col == c && exp_o.row == r) && n < 2 * F) begin
      tick();
      n++;
    end
    check("wait_pos_reached", int'(exp_o.col == c && exp_o.row == r), 1);
  endtask

  task automatic check_gen_align(input string name);
    int p;
    p = (gen_pos - 2 - shift + 2 * F) % F;
    check({name, "_col"}, int'(col), p % TC);
    check({name, "_row"}, int'(row), p / TC);
  endtask

  initial begin
    int n_fs, n_err, rst_row, p;
    act_tbl[0] = '{AC - 1, AR - 1, 1'b1};
    act_tbl[1] = '{AC,     AR - 1, 1'b0};
    act_tbl[2] = '{0,      AR,     1'b0};
    act_tbl[3] = '{TC - 1, TR - 1, 1'b0};
    act_tbl[4] = '{0,      0,      1'b1};
    act_tbl[5] = '{AC - 1, 0,      1'b1};
    act_tbl[6] = '{5,      5,      1'b1};

    rst_n = 1'b0;
    shift = 0;
    drop_pending = 1'b0;
    drop_row = 0;
    gen_pos = 0;
    hsync = 1'b1;
    vsync = 1'b1;
    vfall_cnt = 0;
    v_lock_cyc = -100;
    model_reset();
    drive();

    // reset state
    repeat (3) tick();
    check("reset_col", int'(col), 0);
    check("reset_row", int'(row), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_active", int'(active), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;

    // clean stream: lock on the third vsync edge, then track the generator
    wait_lock(5 * F, 1'b1, "initial");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_gen_align("align_initial");
    end

    // three locked frames: one frame_start per frame at (0,0), no err
    n_fs = 0;
    n_err = 0;
    for (int i = 0; i < 3 * F; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        n_fs++;
        check("fs_col", int'(col), 0);
        check("fs_row", int'(row), 0);
      end
      if (err === 1'b1) n_err++;
    end
    check("fs_count_3_frames", n_fs, 3);
    check("err_count_clean", n_err, 0);

    // active window boundaries
    for (int i = 0; i < 7; i++) begin
      wait_pos(act_tbl[i].col, act_tbl[i].row);
      check("act_tbl_col", int'(col), act_tbl[i].col);
      check("act_tbl_row", int'(row), act_tbl[i].row);
      check("act_tbl_active", int'(active), int'(act_tbl[i].active));
    end

    // dropped hsync on one random line
    wait_pos(0, 0);
    drop_row = $urandom_range(2, AR - 1);
    drop_pending = 1'b1;
    n_err = 0;
    for (int i = 0; i < F; i++) begin
      tick();
      if (err === 1'b1) begin
        n_err++;
        check("drop_err_col", int'(col), HE);
        check("drop_err_row", int'(row), drop_row);
        check("drop_err_unlocked", int'(locked), 0);
      end
    end
    check("drop_err_count", n_err, 1);
    wait_lock(4 * F, 1'b0, "drop_relock");

    // phase shift of the whole stream by a random 1..3 pixels from row 10
    p = 0;
    while (gen_pos != 10 * TC && p < 2 * F) begin
      tick();
      p++;
    end
    shift = $urandom_range(1, 3);
    n_err = 0;
    for (int i = 0; i < 2 * F; i++) begin
      tick();
      if (err === 1'b1) n_err++;
    end
    check("shift_err_count", n_err, 1);
    wait_lock(4 * F, 1'b0, "shift_relock");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_gen_align("align_shifted");
    end

    // asynchronous reset mid-line, then clean relock
    rst_row = $urandom_range(1, 20);
    wait_pos(10, rst_row);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_col", int'(col), 0);
    check("async_rst_row", int'(row), 0);
    check("async_rst_active", int'(active), 0);
    check("async_rst_fs", int'(frame_start), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_err", int'(err), 0);
    vfall_cnt = 0;
    v_lock_cyc = -100;
    repeat (5) tick();
    rst_n = 1'b1;
    wait_lock(5 * F, 1'b1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
